sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum output.
- Accepts a stream of sums over a valid/ready handshake and accumulates FRAME_LEN accepted sums into a wider total.
- Presents the frame total, with a sticky overflow flag, on a second valid/ready handshake.
- Holds the result under backpressure until the consumer takes it.

Parameters:
- SUM_W, 5: width of the incoming sum; matches the adder output.
- FRAME_LEN, 4: number of accepted sums per frame; must be ≥1.
- ACC_W, 8: accumulator and result width; must be ≥ SUM_W.
- CNT_W, $clog2(FRAME_LEN+1): width of count_o.

Ports:
- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_ni, input, 1: reset, synchronous, active-low.
- sum_i, input, SUM_W: sum from the adder, unsigned.
- sum_valid_i, input, 1: sum_i is valid this cycle.
- sum_ready_o, output, 1: block will accept sum_i this cycle.
- clear_i, input, 1: synchronous frame abort, active-high.
- acc_o, output, ACC_W: running total in ACCUM; frame total in HOLD.
- acc_valid_o, output, 1: acc_o holds a completed frame total.
- acc_ready_i, input, 1: consumer accepts acc_o.
- ovf_o, output, 1: sticky carry-out of the accumulator within the current frame.
- count_o, output, CNT_W: sums accepted in the current frame.

Behaviour:
- Reset: applied on a rising edge with rst_ni=0.
  - Next-cycle outputs: state=ACCUM, acc_o=0, count_o=0, ovf_o=0, acc_valid_o=0.
  - sum_ready_o=0 in any cycle where rst_ni=0.
  - Reset mid-frame or in HOLD discards everything, including an unconsumed result.
- States: ACCUM and HOLD only.
- sum_ready_o = rst_ni && (state==ACCUM) && !clear_i. This is the only combinational input-to-output path.
- Accept event: sum_valid_i && sum_ready_o.
- ACCUM, on accept:
  - acc ← (acc + zero-extended sum_i) mod 2^ACC_W.
  - ovf ← ovf | carry-out of that add.
  - count ← count+1.
  - If the accept makes count==FRAME_LEN, go to HOLD. acc_valid_o=1 on the following cycle, so latency from the last accept to valid is 1 cycle.
- ACCUM, no accept: all state holds. Bubbles on sum_valid_i do not count toward the frame.
- HOLD:
  - acc_valid_o=1 and sum_ready_o=0.
  - acc_o, ovf_o and count_o (=FRAME_LEN) stay stable while acc_ready_i=0.
  - On acc_ready_i=1: next cycle state=ACCUM, acc=0, ovf=0, count=0, acc_valid_o=0.
  - No new sum is accepted in the handshake cycle.
- clear_i=1 with rst_ni=1: highest priority after reset, effective in either state.
  - Next cycle state=ACCUM, acc=0, ovf=0, count=0, acc_valid_o=0.
  - A sum presented in the same cycle is not accepted (sum_ready_o=0).
  - A result pending in HOLD is dropped.
- clear_i together with acc_ready_i in HOLD: treated as clear; the result is not considered delivered.
- FRAME_LEN=1: every accept goes directly to HOLD.
- acc_valid_o is registered; acc_o and ovf_o are registered.

Test Plan:
1. Reset: rst_ni=0 for 2 cycles with sum_valid_i=1, sum_i=9 → sum_ready_o=0 throughout; after release all outputs 0 and sum_ready_o=1.
2. Normal frame: sums 3,7,12,30 back-to-back → count_o 1,2,3,4. acc_valid_o=1 one cycle after the 4th accept with acc_o=52, ovf_o=0. Then acc_ready_i=1 → next cycle acc_o=0, acc_valid_o=0, sum_ready_o=1.
3. Bubbles and backpressure:
   - sums 5,_,_,6,_,1,2 (gaps = sum_valid_i low) → acc_o=14 in HOLD.
   - Hold acc_ready_i=0 for 5 cycles with sum_valid_i=1, sum_i=30 → acc_o stays 14, sum_ready_o=0, count_o=4.
4. Overflow (ACC_W=6): sums 30,30,30,30 → acc_o=56 (120 mod 64), ovf_o=1 in HOLD. After handshake ovf_o=0, and the next frame 1,1,1,1 gives acc_o=4, ovf_o=0.
5. Clear mid-frame: accept 10,20, then clear_i=1 with sum_valid_i=1, sum_i=15 → 15 not accepted; next cycle acc_o=0, count_o=0. Then 1,2,3,4 → acc_o=10.
6. Clear in HOLD: frame total 52 pending, clear_i=1 with acc_ready_i=1 → next cycle acc_valid_o=0, acc_o=0, sum_ready_o=1.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates FRAME_LEN accepted adder sums into a wider total and presents the
// frame result, with a sticky carry-out flag, over a valid/ready handshake.
module sum_accumulator #(
  parameter int SUM_W     = 5,
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_valid_i,
  output logic             sum_ready_o,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             ovf_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   add_res;
  logic             accept;

  assign sum_ready_o = rst_ni && (state_q == ACCUM) && !clear_i;
  assign accept      = sum_valid_i && sum_ready_o;
  // One extra bit captures the carry-out of the accumulate.
  assign add_res     = {1'b0, acc_q} + (ACC_W + 1)'(sum_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      // Abort wins over delivery: a pending result is dropped, not handed off.
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = add_res[ACC_W-1:0];
            ovf_d = ovf_q | add_res[ACC_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (acc_ready_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_o       = acc_q;
  assign ovf_o       = ovf_q;
  assign count_o     = cnt_q;
  assign acc_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized + directed bench for sum_accumulator: a frame-level reference model
// feeds an expected-result queue that a separate monitor drains on each handshake.
module tb_sum_accumulator;
  localparam int SUM_W = 5;
  localparam int FL    = 4;
  localparam int AW    = 6;
  localparam int CW    = $clog2(FL + 1);
  localparam int MOD   = 1 << AW;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [SUM_W-1:0] sum_i = '0;
  logic             sum_valid_i = 1'b0;
  logic             sum_ready_o;
  logic             clear_i = 1'b0;
  logic [AW-1:0]    acc_o;
  logic             acc_valid_o;
  logic             acc_ready_i = 1'b0;
  logic             ovf_o;
  logic [CW-1:0]    count_o;

  sum_accumulator #(.SUM_W(SUM_W), .FRAME_LEN(FL), .ACC_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sum_i(sum_i), .sum_valid_i(sum_valid_i),
    .sum_ready_o(sum_ready_o), .clear_i(clear_i), .acc_o(acc_o),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .ovf_o(ovf_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: the list of sums accepted in the current frame and
  // whether a completed frame is waiting for the consumer.
  int unsigned frame[$];
  bit          m_hold  = 1'b0;
  bit          m_known = 1'b0;
  int unsigned exp_q[$];   // {ovf, acc} of each frame the consumer should receive

  function automatic int unsigned frame_sum();
    int unsigned t = 0;
    foreach (frame[i]) t += frame[i];
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive one cycle, check at the falling
  // edge, then advance the model across the next rising edge.
  task automatic cycle(input bit r, input bit v, input int unsigned s, input bit c, input bit a);
    rst_ni = r; sum_valid_i = v; sum_i = SUM_W'(s); clear_i = c; acc_ready_i = a;
    if (m_known && r && !c && a && m_hold)
      exp_q.push_back(((frame_sum() >= MOD) ? MOD : 0) + (frame_sum() % MOD));
    @(negedge clk_i);
    chk("sum_ready", sum_ready_o, r && m_known && !m_hold && !c);
    if (m_known) begin
      chk("acc_valid", acc_valid_o, m_hold);
      chk("count", count_o, frame.size());
      chk("acc", acc_o, frame_sum() % MOD);
      chk("ovf", ovf_o, frame_sum() >= MOD);
    end
    if (!r || c) begin
      frame.delete(); m_hold = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_hold) begin
        if (a) begin frame.delete(); m_hold = 1'b0; end
      end else if (v) begin
        frame.push_back(s);
        if (frame.size() == FL) m_hold = 1'b1;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic monitor();
    int unsigned e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && acc_valid_o && acc_ready_i && !clear_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_acc", acc_o, e % MOD);
          chk("frame_ovf", ovf_o, e / MOD);
          chk("frame_count", count_o, FL);
        end
      end
    end
  endtask

  task automatic frame4(input int unsigned a0, a1, a2, a3);
    cycle(1, 1, a0, 0, 0); cycle(1, 1, a1, 0, 0);
    cycle(1, 1, a2, 0, 0); cycle(1, 1, a3, 0, 0);
  endtask

  initial begin
    fork monitor(); join_none
    @(posedge clk_i); #1;
    // reset with a sum offered: never accepted
    cycle(0, 1, 9, 0, 0);
    cycle(0, 1, 9, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // normal frame 3+7+12+30 = 52
    frame4(3, 7, 12, 30);
    cycle(1, 0, 0, 0, 0);
    chk("hold_total_52", acc_o, 52);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    // bubbles then backpressure with sums offered
    cycle(1, 1, 5, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 6, 0, 0); cycle(1, 0, 0, 0, 0); cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 30, 0, 0);
    chk("hold_total_14", acc_o, 14);
    cycle(1, 0, 0, 0, 1);
    // overflow: 120 mod 64 = 56 with carry, then a clean frame
    frame4(30, 30, 30, 30);
    cycle(1, 0, 0, 0, 0);
    chk("ovf_total_56", acc_o, 56);
    chk("ovf_flag", ovf_o, 1);
    cycle(1, 0, 0, 0, 1);
    frame4(1, 1, 1, 1);
    cycle(1, 0, 0, 0, 1);
    // clear mid-frame drops the offered 15
    cycle(1, 1, 10, 0, 0); cycle(1, 1, 20, 0, 0);
    cycle(1, 1, 15, 1, 0);
    frame4(1, 2, 3, 4);
    cycle(1, 0, 0, 0, 0);
    chk("after_clear_10", acc_o, 10);
    cycle(1, 0, 0, 0, 1);
    // clear together with ready in HOLD: result discarded
    frame4(3, 7, 12, 30);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(63) != 0), ($urandom_range(3) != 0), $urandom_range(31),
            ($urandom_range(15) == 0), $urandom_range(1));
    // drain any pending frame
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    chk("undelivered_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
